// File: rtl/comp_buf_sched_if.sv
// rtl/comp_buf_sched_if.sv - issuer, done, buffer-read and consumer handshake bundle for comp_buf_sched
interface comp_buf_sched_if #(
  parameter int N_THREADS = 16
);
  localparam int TW = $clog2(N_THREADS);

  logic                 comp_wr_en;
  logic [TW-1:0]        comp_wr_thread_num;
  logic                 buf_wr_en;
  logic                 comp_done_en;
  logic [TW-1:0]        comp_done_thread_num;
  logic [N_THREADS-1:0] thread_busy;
  logic [TW-1:0]        rd_thread_num1;
  logic                 data1_valid;
  logic                 data1_rd;
  logic [TW-1:0]        rd_thread_num2;
  logic                 data2_valid;
  logic                 data2_rd;
  logic [1:0]           err;

  modport slave (
    input  comp_wr_en, comp_wr_thread_num, comp_done_en, comp_done_thread_num,
    input  data1_rd, data2_rd,
    output buf_wr_en, thread_busy, rd_thread_num1, data1_valid,
    output rd_thread_num2, data2_valid, err
  );

  modport master (
    output comp_wr_en, comp_wr_thread_num, comp_done_en, comp_done_thread_num,
    output data1_rd, data2_rd,
    input  buf_wr_en, thread_busy, rd_thread_num1, data1_valid,
    input  rd_thread_num2, data2_valid, err
  );
endinterface

// File: rtl/comp_buf_sched.sv
// rtl/comp_buf_sched.sv - per-thread computation bookkeeping and two round-robin comp_buf read channels
module comp_buf_sched #(
  parameter int N_THREADS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  comp_buf_sched_if.slave   bus
);
  localparam int TW = $clog2(N_THREADS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_VALID} state_t;

  logic [N_THREADS-1:0] active_q, active_d;
  logic [1:0]           err_q, err_d;
  logic [N_THREADS-1:0] pend_q [2];
  logic [N_THREADS-1:0] pend_d [2];
  state_t               st_q   [2];
  state_t               st_d   [2];
  logic [TW-1:0]        ptr_q  [2];
  logic [TW-1:0]        ptr_d  [2];
  logic [TW-1:0]        rd_q   [2];
  logic [TW-1:0]        rd_d   [2];
  logic [TW-1:0]        sel    [2];
  logic [1:0]           vld_q, vld_d;
  logic [1:0]           ack;

  logic [N_THREADS-1:0] done_mask, wr_mask, act_after_done;
  logic                 accept;

  // Done is applied before the busy check so a thread can be finished and re-issued in one cycle.
  assign done_mask      = bus.comp_done_en ? (N_THREADS'(1) << bus.comp_done_thread_num) : '0;
  assign act_after_done = active_q & ~done_mask;
  assign accept         = bus.comp_wr_en & ~act_after_done[bus.comp_wr_thread_num];
  assign wr_mask        = accept ? (N_THREADS'(1) << bus.comp_wr_thread_num) : '0;
  assign ack            = {bus.data2_rd, bus.data1_rd};

  assign active_d = act_after_done | wr_mask;
  assign err_d    = err_q | {bus.comp_done_en & ~active_q[bus.comp_done_thread_num],
                             bus.comp_wr_en & ~accept};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k]   = st_q[k];
      ptr_d[k]  = ptr_q[k];
      rd_d[k]   = rd_q[k];
      vld_d[k]  = vld_q[k];
      pend_d[k] = pend_q[k];
      sel[k]    = ptr_q[k];
      // Descending scan: the last hit is the nearest pending thread at or after the pointer.
      for (int i = N_THREADS - 1; i >= 0; i--) begin
        if (pend_q[k][ptr_q[k] + TW'(i)]) sel[k] = ptr_q[k] + TW'(i);
      end
      case (st_q[k])
        S_IDLE: begin
          if (|pend_q[k]) begin
            rd_d[k] = sel[k];
            st_d[k] = S_ADDR;
          end
        end
        S_ADDR: begin
          st_d[k]  = S_VALID;
          vld_d[k] = 1'b1;
        end
        S_VALID: begin
          if (ack[k]) begin
            pend_d[k][rd_q[k]] = 1'b0;
            ptr_d[k]           = rd_q[k] + TW'(1);
            vld_d[k]           = 1'b0;
            st_d[k]            = S_IDLE;
          end
        end
        default: st_d[k] = S_IDLE;
      endcase
      pend_d[k] = pend_d[k] | wr_mask;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= '0;
      err_q    <= '0;
      vld_q    <= '0;
      for (int k = 0; k < 2; k++) begin
        pend_q[k] <= '0;
        st_q[k]   <= S_IDLE;
        ptr_q[k]  <= '0;
        rd_q[k]   <= '0;
      end
    end else begin
      active_q <= active_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      for (int k = 0; k < 2; k++) begin
        pend_q[k] <= pend_d[k];
        st_q[k]   <= st_d[k];
        ptr_q[k]  <= ptr_d[k];
        rd_q[k]   <= rd_d[k];
      end
    end
  end

  assign bus.buf_wr_en      = accept;
  assign bus.thread_busy    = active_q;
  assign bus.err            = err_q;
  assign bus.rd_thread_num1 = rd_q[0];
  assign bus.data1_valid    = vld_q[0];
  assign bus.rd_thread_num2 = rd_q[1];
  assign bus.data2_valid    = vld_q[1];
endmodule

// File: tb/tb_comp_buf_sched.sv
// tb/tb_comp_buf_sched.sv - directed and randomized checks of comp_buf_sched against a cycle-level reference model
module tb_comp_buf_sched;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_buf_sched_if #(.N_THREADS(N)) bus ();
  comp_buf_sched #(.N_THREADS(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: thread sets as bit arrays, each channel as "thread granted and the cycle its data turns valid".
  bit         m_act  [N];
  bit         m_pend [2][N];
  logic [1:0] m_err;
  int         m_cur  [2];
  int         m_vat  [2];
  int         m_rd   [2];
  int         m_ptr  [2];
  int         cyc;
  logic       last_bwe;
  int         served[$];

  function automatic void mreset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_pend[0][i] = 0; m_pend[1][i] = 0;
    end
    m_err = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = -1; m_vat[k] = 0; m_rd[k] = 0; m_ptr[k] = 0;
    end
    cyc = 0;
  endfunction

  function automatic bit mvalid(input int k);
    return (m_cur[k] >= 0) && (cyc >= m_vat[k]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_regs();
    logic [N-1:0] busy;
    for (int i = 0; i < N; i++) busy[i] = m_act[i];
    chk("thread_busy", 32'(bus.thread_busy), 32'(busy));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("data1_valid", 32'(bus.data1_valid), 32'(mvalid(0)));
    chk("data2_valid", 32'(bus.data2_valid), 32'(mvalid(1)));
    chk("rd_thread_num1", 32'(bus.rd_thread_num1), 32'(m_rd[0]));
    chk("rd_thread_num2", 32'(bus.rd_thread_num2), 32'(m_rd[1]));
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input bit we, input int wt, input bit de, input int dt, input bit a1, input bit a2);
    bit after_done [N];
    bit acc;
    bit v;
    bit ackk;
    int s;
    check_regs();
    bus.comp_wr_en           = we;
    bus.comp_wr_thread_num   = 4'(wt);
    bus.comp_done_en         = de;
    bus.comp_done_thread_num = 4'(dt);
    bus.data1_rd             = a1;
    bus.data2_rd             = a2;
    #1;
    for (int i = 0; i < N; i++) after_done[i] = m_act[i] && !(de && (i == dt));
    acc = we && !after_done[wt];
    chk("buf_wr_en", 32'(bus.buf_wr_en), 32'(acc));
    last_bwe = bus.buf_wr_en;
    if (we && !acc) m_err[0] = 1'b1;
    if (de && !m_act[dt]) m_err[1] = 1'b1;
    for (int i = 0; i < N; i++) m_act[i] = after_done[i];
    if (acc) m_act[wt] = 1;
    for (int k = 0; k < 2; k++) begin
      v    = mvalid(k);
      ackk = (k == 0) ? a1 : a2;
      if (m_cur[k] < 0) begin
        s = -1;
        for (int j = N - 1; j >= 0; j--) if (m_pend[k][(m_ptr[k] + j) % N]) s = (m_ptr[k] + j) % N;
        if (s >= 0) begin
          m_cur[k] = s; m_rd[k] = s; m_vat[k] = cyc + 2;
        end
      end else if (v && ackk) begin
        m_pend[k][m_cur[k]] = 0;
        m_ptr[k] = (m_cur[k] + 1) % N;
        m_cur[k] = -1;
      end
      if (acc) m_pend[k][wt] = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_valid1(input int maxc);
    int n = 0;
    while (!bus.data1_valid && n < maxc) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end
    if (!bus.data1_valid) begin
      tests++;
      fails++;
      $error("FAIL wait_valid1: data1_valid observed 0 expected 1 within %0d cycles", maxc);
    end
  endtask

  task automatic do_reset();
    bus.comp_wr_en = 0; bus.comp_done_en = 0; bus.data1_rd = 0; bus.data2_rd = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mreset();
    check_regs();
    rst = 1'b0;
  endtask

  initial begin
    bus.comp_wr_en = 0; bus.comp_wr_thread_num = '0;
    bus.comp_done_en = 0; bus.comp_done_thread_num = '0;
    bus.data1_rd = 0; bus.data2_rd = 0;
    mreset();
    do_reset();

    // Single write to thread 5: valid on both channels three cycles later.
    step(1, 5, 0, 0, 0, 0);
    chk("tp1_buf_wr_en", 32'(last_bwe), 32'd1);
    chk("tp1_thread_busy", 32'(bus.thread_busy), 32'h0020);
    idle(2);
    chk("tp1_valid1", 32'(bus.data1_valid), 32'd1);
    chk("tp1_rd1", 32'(bus.rd_thread_num1), 32'd5);
    chk("tp1_valid2", 32'(bus.data2_valid), 32'd1);
    chk("tp1_rd2", 32'(bus.rd_thread_num2), 32'd5);
    step(0, 0, 1, 5, 1, 1);

    // Channel 1 acked immediately, channel 2 never acked.
    step(1, 3, 0, 0, 1, 0);
    step(1, 9, 0, 0, 1, 0);
    step(1, 14, 0, 0, 1, 0);
    served.delete();
    for (int i = 0; i < 10; i++) begin
      if (bus.data1_valid) served.push_back(int'(bus.rd_thread_num1));
      step(0, 0, 0, 0, 1, 0);
    end
    chk("tp2_served_cnt", 32'(served.size()), 32'd3);
    if (served.size() == 3) begin
      chk("tp2_served0", 32'(served[0]), 32'd3);
      chk("tp2_served1", 32'(served[1]), 32'd9);
      chk("tp2_served2", 32'(served[2]), 32'd14);
    end
    chk("tp2_valid2_held", 32'(bus.data2_valid), 32'd1);
    chk("tp2_rd2_stuck", 32'(bus.rd_thread_num2), 32'd3);

    // Round-robin order after serving 3, then wrap from 15 to 0.
    do_reset();
    step(1, 3, 0, 0, 0, 0);
    wait_valid1(6);
    chk("rr_first", 32'(bus.rd_thread_num1), 32'd3);
    step(1, 2, 0, 0, 0, 0);
    step(1, 6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    wait_valid1(6);
    chk("rr_after_ptr4", 32'(bus.rd_thread_num1), 32'd6);
    step(0, 0, 0, 0, 1, 0);
    wait_valid1(6);
    chk("rr_then_2", 32'(bus.rd_thread_num1), 32'd2);
    step(0, 0, 0, 0, 1, 0);
    step(1, 14, 0, 0, 0, 0);
    wait_valid1(6);
    chk("wrap_14", 32'(bus.rd_thread_num1), 32'd14);
    step(1, 0, 0, 0, 0, 0);
    step(1, 15, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    wait_valid1(6);
    chk("wrap_15", 32'(bus.rd_thread_num1), 32'd15);
    step(0, 0, 0, 0, 1, 0);
    wait_valid1(6);
    chk("wrap_0", 32'(bus.rd_thread_num1), 32'd0);
    step(0, 0, 0, 0, 1, 0);

    // Busy rejection, then done+write to the same thread in one cycle.
    do_reset();
    step(1, 7, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0);
    chk("busy_buf_wr_en", 32'(last_bwe), 32'd0);
    chk("busy_err", 32'(bus.err), 32'd1);
    chk("busy_thread_busy", 32'(bus.thread_busy), 32'h0080);
    step(1, 7, 1, 7, 0, 0);
    chk("redo_buf_wr_en", 32'(last_bwe), 32'd1);
    chk("redo_busy7", 32'(bus.thread_busy[7]), 32'd1);
    chk("redo_err", 32'(bus.err), 32'd1);
    step(0, 0, 1, 1, 0, 0);
    chk("idle_done_err", 32'(bus.err), 32'd3);

    // Asynchronous reset while channel 1 is presenting data.
    wait_valid1(6);
    #2 rst = 1'b1;
    #1;
    chk("async_valid1", 32'(bus.data1_valid), 32'd0);
    chk("async_valid2", 32'(bus.data2_valid), 32'd0);
    chk("async_busy", 32'(bus.thread_busy), 32'd0);
    chk("async_err", 32'(bus.err), 32'd0);
    chk("async_rd1", 32'(bus.rd_thread_num1), 32'd0);
    @(negedge clk);
    mreset();
    rst = 1'b0;
    idle(6);
    chk("post_rst_valid1", 32'(bus.data1_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit we, de, a1, a2;
      int wt, dt;
      we = ($urandom_range(0, 2) == 0);
      wt = $urandom_range(0, N - 1);
      de = ($urandom_range(0, 3) == 0);
      dt = $urandom_range(0, N - 1);
      a1 = $urandom_range(0, 1) == 1;
      a2 = $urandom_range(0, 3) == 0;
      step(we, wt, de, dt, a1, a2);
    end
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1, 1);
    check_regs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
